// File: rtl/ehr_pkg.sv
// Shared definitions for the ordered-register FIFO: width helpers, the pointer
// container type and the method-order port assignment of EHR_2.
package ehr_pkg;

  // Number of write ports on an EHR_2 and the method each port serves.
  // Lower port index = earlier in the schedule (deq/enq before clear).
  localparam int unsigned EHR_PORTS    = 2;
  localparam int unsigned PORT_DEQ_ENQ = 0;
  localparam int unsigned PORT_CLEAR   = 1;

  // Widest pointer any instance may need; narrower pointers are cast into it.
  localparam int unsigned PTR_W_MAX = 16;
  typedef logic [PTR_W_MAX-1:0] ptr_t;

  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  // Advance a pointer by one, wrapping at depth (depth is a power of two).
  function automatic ptr_t ptr_next(input ptr_t p, input int unsigned depth);
    return (p + ptr_t'(1)) & ptr_t'(depth - 1);
  endfunction

endpackage

// File: rtl/EHR_2.sv
// Two-port ordered register: port 1 is scheduled after port 0, so a port-1
// write overrides a same-cycle port-0 write. Reads return the pre-edge value.
module EHR_2
  import ehr_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic                             CLK,
  input  logic                             RST_N,
  input  logic [EHR_PORTS-1:0]             en,
  input  logic [EHR_PORTS-1:0][WIDTH-1:0]  wr_data,
  output logic [WIDTH-1:0]                 q
);

  logic [WIDTH-1:0] nxt;

  always_comb begin
    nxt = q;
    if (en[PORT_DEQ_ENQ]) nxt = wr_data[PORT_DEQ_ENQ];
    if (en[PORT_CLEAR])   nxt = wr_data[PORT_CLEAR];
  end

  // NOTE: sequential state uses non-blocking assignment so every register
  // samples its pre-edge inputs regardless of block evaluation order.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) q <= '0;
    else        q <= nxt;
  end

endmodule

// File: rtl/ehr_cf_fifo.sv
// Pipeline FIFO with method order deq < enq < clear. Define
// EHR_CF_FIFO_BYPASS_EN to let an enqueue on an empty FIFO feed the head directly.
module ehr_cf_fifo
  import ehr_pkg::*;
#(
  parameter int unsigned DATA_SZ = 1,
  parameter int unsigned DEPTH   = 4
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic [DATA_SZ-1:0]        enq_data,
  input  logic                      EN_enq,
  output logic                      RDY_enq,
  output logic [DATA_SZ-1:0]        first,
  output logic                      RDY_deq,
  input  logic                      EN_deq,
  input  logic                      EN_clear,
  output logic [cnt_w(DEPTH)-1:0]   count
);

  localparam int unsigned CW = cnt_w(DEPTH);
  localparam int unsigned PW = ptr_w(DEPTH);

  logic [DATA_SZ-1:0] mem [DEPTH];
  logic [PW-1:0]      rd_ptr;
  logic [PW-1:0]      wr_ptr;

  logic               enq_acc;
  logic               deq_acc;
  logic               bypass_take;
  logic [CW-1:0]      cnt_upd;

  logic [EHR_PORTS-1:0]         cnt_en,  rd_en,  wr_en;
  logic [EHR_PORTS-1:0][CW-1:0] cnt_wr;
  logic [EHR_PORTS-1:0][PW-1:0] rd_wr,   wr_wr;

  // NOTE: every signal assigned here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    RDY_enq     = (count != CW'(DEPTH)) || EN_deq;
`ifdef EHR_CF_FIFO_BYPASS_EN
    // Reset gates the bypass so the head reads invalid while RST_N is low.
    RDY_deq     = (count != '0) || (RST_N && EN_enq);
    first       = (count == '0 && EN_enq) ? enq_data : mem[rd_ptr];
    bypass_take = RST_N && (count == '0) && EN_enq && EN_deq;
`else
    RDY_deq     = (count != '0);
    first       = mem[rd_ptr];
    bypass_take = 1'b0;
`endif
    // A bypassed enq+deq pair passes straight through and touches no state.
    deq_acc = EN_deq && RDY_deq && !bypass_take;
    enq_acc = EN_enq && RDY_enq && !bypass_take;
    cnt_upd = count + CW'(enq_acc) - CW'(deq_acc);

    cnt_en                = '0;
    cnt_en[PORT_DEQ_ENQ]  = enq_acc || deq_acc;
    cnt_en[PORT_CLEAR]    = EN_clear;
    cnt_wr                = '0;
    cnt_wr[PORT_DEQ_ENQ]  = cnt_upd;

    rd_en                 = '0;
    rd_en[PORT_DEQ_ENQ]   = deq_acc;
    rd_en[PORT_CLEAR]     = EN_clear;
    rd_wr                 = '0;
    rd_wr[PORT_DEQ_ENQ]   = PW'(ptr_next(ptr_t'(rd_ptr), DEPTH));

    wr_en                 = '0;
    wr_en[PORT_DEQ_ENQ]   = enq_acc;
    wr_en[PORT_CLEAR]     = EN_clear;
    wr_wr                 = '0;
    wr_wr[PORT_DEQ_ENQ]   = PW'(ptr_next(ptr_t'(wr_ptr), DEPTH));
  end

  EHR_2 #(.WIDTH(CW)) u_count (
    .CLK(CLK), .RST_N(RST_N), .en(cnt_en), .wr_data(cnt_wr), .q(count)
  );

  EHR_2 #(.WIDTH(PW)) u_rd_ptr (
    .CLK(CLK), .RST_N(RST_N), .en(rd_en), .wr_data(rd_wr), .q(rd_ptr)
  );

  EHR_2 #(.WIDTH(PW)) u_wr_ptr (
    .CLK(CLK), .RST_N(RST_N), .en(wr_en), .wr_data(wr_wr), .q(wr_ptr)
  );

  // NOTE: the storage array has no reset; occupancy lives in the pointers and
  // count, so stale entries are never observable and the array maps to RAM.
  always_ff @(posedge CLK) begin
    if (enq_acc && !EN_clear) mem[wr_ptr] <= enq_data;
  end

endmodule

// File: tb/tb_ehr_cf_fifo.sv
// Directed bench for ehr_cf_fifo (DEPTH=4, DATA_SZ=8) against a queue model.
module tb_ehr_cf_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic          CLK      = 1'b0;
  logic          RST_N    = 1'b0;
  logic [DW-1:0] enq_data = '0;
  logic          EN_enq   = 1'b0;
  logic          EN_deq   = 1'b0;
  logic          EN_clear = 1'b0;
  logic          RDY_enq;
  logic          RDY_deq;
  logic [DW-1:0] first;
  logic [2:0]    count;

  int n_checks = 0;
  int n_fail   = 0;

  ehr_cf_fifo #(.DATA_SZ(DW), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST_N(RST_N), .enq_data(enq_data), .EN_enq(EN_enq),
    .RDY_enq(RDY_enq), .first(first), .RDY_deq(RDY_deq), .EN_deq(EN_deq),
    .EN_clear(EN_clear), .count(count)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: the FIFO contents as a queue, head at index 0.
  logic [DW-1:0] q[$];

  function automatic bit model_bypass();
`ifdef EHR_CF_FIFO_BYPASS_EN
    return RST_N && (q.size() == 0) && EN_enq;
`else
    return 1'b0;
`endif
  endfunction

  always @(negedge RST_N) q.delete();

  always @(posedge CLK) begin
    if (RST_N) begin
      if (EN_clear) q.delete();
      else if (!(model_bypass() && EN_deq)) begin
        bit can_deq, can_enq;
        can_deq = EN_deq && (q.size() != 0);
        can_enq = EN_enq && ((q.size() != DEPTH) || EN_deq);
        if (can_deq) void'(q.pop_front());
        if (can_enq) q.push_back(enq_data);
      end
    end
  end

  // Per-cycle comparison, 2 time units after the input-driving edge.
  always @(negedge CLK) begin
    #2;
    begin
      logic exp_rdy_deq, exp_rdy_enq;
      exp_rdy_deq = (RST_N && q.size() != 0) || model_bypass();
      exp_rdy_enq = (q.size() != DEPTH) || EN_deq;
      check("model_count",   32'(count),   32'(q.size()));
      check("model_rdy_deq", 32'(RDY_deq), 32'(exp_rdy_deq));
      check("model_rdy_enq", 32'(RDY_enq), 32'(exp_rdy_enq));
      if (exp_rdy_deq)
        check("model_first", 32'(first), (q.size() != 0) ? 32'(q[0]) : 32'(enq_data));
    end
  end

  task automatic step(input logic enq, input logic [DW-1:0] d, input logic deq, input logic clr);
    @(negedge CLK);
    EN_enq = enq; enq_data = d; EN_deq = deq; EN_clear = clr;
    #3;
  endtask

  task automatic idle();
    step(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  logic [DW-1:0] fill_vals  [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic [DW-1:0] drain_vals [4] = '{8'h22, 8'h33, 8'h44, 8'h55};

  initial begin
    #1;
    check("reset_count",   32'(count),   32'd0);
    check("reset_rdy_deq", 32'(RDY_deq), 32'd0);
    check("reset_rdy_enq", 32'(RDY_enq), 32'd1);
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;

    // Fill to full.
    for (int i = 0; i < 4; i++) begin
      step(1'b1, fill_vals[i], 1'b0, 1'b0);
      check("fill_count", 32'(count), 32'(i));
    end
    idle();
    check("full_count",   32'(count),   32'd4);
    check("full_rdy_enq", 32'(RDY_enq), 32'd0);
    check("full_first",   32'(first),   32'h11);

    // Enqueue refused while full with no dequeue.
    step(1'b1, 8'h99, 1'b0, 1'b0);
    check("refused_rdy_enq", 32'(RDY_enq), 32'd0);
    idle();
    check("refused_count", 32'(count), 32'd4);
    check("refused_first", 32'(first), 32'h11);

    // Simultaneous enq+deq while full.
    step(1'b1, 8'h55, 1'b1, 1'b0);
    check("full_pipe_rdy_enq", 32'(RDY_enq), 32'd1);
    idle();
    check("full_pipe_count", 32'(count), 32'd4);
    check("full_pipe_first", 32'(first), 32'h22);

    // Drain.
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      check("drain_first", 32'(first), 32'(drain_vals[i]));
    end
    idle();
    check("empty_rdy_deq", 32'(RDY_deq), 32'd0);
    check("empty_count",   32'(count),   32'd0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    idle();
    check("empty_deq_count", 32'(count), 32'd0);

    // Streaming with pointer wrap.
    step(1'b1, 8'hA0, 1'b0, 1'b0);
    step(1'b1, 8'hA1, 1'b0, 1'b0);
    step(1'b1, 8'hA2, 1'b1, 1'b0);
    step(1'b1, 8'hA3, 1'b1, 1'b0);
    idle();
    check("stream_count", 32'(count), 32'd2);
    check("stream_first", 32'(first), 32'hA2);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // Clear overrides a same-cycle enq and deq.
    step(1'b1, 8'h01, 1'b0, 1'b0);
    step(1'b1, 8'h02, 1'b0, 1'b0);
    step(1'b1, 8'h03, 1'b0, 1'b0);
    idle();
    check("pre_clear_count", 32'(count), 32'd3);
    step(1'b1, 8'h04, 1'b1, 1'b1);
    idle();
    check("clear_count",   32'(count),   32'd0);
    check("clear_rdy_deq", 32'(RDY_deq), 32'd0);
    check("clear_rdy_enq", 32'(RDY_enq), 32'd1);
    step(1'b1, 8'h66, 1'b0, 1'b0);
    idle();
    check("post_clear_first", 32'(first), 32'h66);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // Asynchronous reset in the middle of a cycle.
    step(1'b1, 8'h10, 1'b0, 1'b0);
    step(1'b1, 8'h20, 1'b0, 1'b0);
    idle();
    check("pre_reset_count", 32'(count), 32'd2);
    RST_N = 1'b0;
    #1;
    check("async_reset_count",   32'(count),   32'd0);
    check("async_reset_rdy_deq", 32'(RDY_deq), 32'd0);
    check("async_reset_rdy_enq", 32'(RDY_enq), 32'd1);
    idle();
    @(negedge CLK);
    RST_N = 1'b1;
    step(1'b1, 8'hA5, 1'b0, 1'b0);
    idle();
    check("post_reset_first", 32'(first), 32'hA5);
    check("post_reset_count", 32'(count), 32'd1);
    step(1'b0, 8'h00, 1'b1, 1'b0);

`ifdef EHR_CF_FIFO_BYPASS_EN
    idle();
    step(1'b1, 8'h7E, 1'b1, 1'b0);
    check("bypass_first",   32'(first),   32'h7E);
    check("bypass_rdy_deq", 32'(RDY_deq), 32'd1);
    idle();
    check("bypass_count", 32'(count), 32'd0);
`endif

    idle();
    idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
